mem_access_ctrl: RTL and testbench

- Load/store sequencer directly upstream of data_memory.
- Accepts one CPU memory request at a time over a valid/ready handshake and drives data_memory's address, value, get and set inputs.
- For loads, waits the memory read latency, captures memout and returns it on a valid/ready response channel.
- Flags out-of-range addresses instead of issuing them.

---
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer in front of data_memory.
// Accepts one CPU request, drives memaddr/memval/memget/memset, waits out the read
// latency for loads and returns the result on a valid/ready response channel.
// Optional saturating access counters: define MEM_ACCESS_STATS_EN.
module mem_access_ctrl #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                 mclk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic [WORD_SIZE-1:0] memaddr,
    output logic [WORD_SIZE-1:0] memval,
    output logic                 memget,
    output logic                 memset,
    input  logic [WORD_SIZE-1:0] memout
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]          ld_count,
    output logic [15:0]          st_count,
    output logic [15:0]          err_count
`endif
);

    typedef enum logic [2:0] {StIdle, StWrite, StRead, StWait, StResp} state_e;

    // One extra bit so a depth of 2**WORD_SIZE still compares correctly.
    localparam logic [WORD_SIZE:0] DepthLim = (WORD_SIZE + 1)'(MEM_DEPTH);
    // Counter reaches zero in the last memget cycle, so it starts at READ_LAT-1.
    localparam logic [2:0]         LatInit  = 3'(READ_LAT - 1);

    state_e               state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 run_q;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] val_q, val_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic accept;
    logic addr_oor;

    assign addr_oor  = ({1'b0, req_addr} >= DepthLim);
    // run_q keeps req_ready low until the first cycle after reset is released.
    assign req_ready = run_q && (state_q == StIdle);
    assign accept    = req_valid && req_ready;

    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign memaddr   = addr_q;
    assign memval    = val_q;
    assign memget    = (state_q == StRead) || (state_q == StWait);
    assign memset    = (state_q == StWrite);

    // Next-state logic: latch the request on accept, count out the read latency.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        val_d   = val_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rdata_d = '0;
                    err_d   = addr_oor;
                    if (addr_oor) begin
                        // Never issued; memaddr/memval keep their last value.
                        state_d = StResp;
                    end else begin
                        addr_d  = req_addr;
                        val_d   = req_we ? req_wdata : '0;
                        cnt_d   = LatInit;
                        state_d = req_we ? StWrite : StRead;
                    end
                end
            end
            StWrite: state_d = StResp;
            StRead, StWait: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = memout;
                    state_d = StResp;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = StWait;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            run_q   <= 1'b0;
            addr_q  <= '0;
            val_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            addr_q  <= addr_d;
            val_q   <= val_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] ld_cnt_q, st_cnt_q, err_cnt_q;

    // Saturating per-kind request counters, bumped on the accept edge.
    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            ld_cnt_q  <= 16'd0;
            st_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else if (accept) begin
            if (addr_oor) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end else if (req_we) begin
                if (st_cnt_q != 16'hFFFF) st_cnt_q <= st_cnt_q + 16'd1;
            end else begin
                if (ld_cnt_q != 16'hFFFF) ld_cnt_q <= ld_cnt_q + 16'd1;
            end
        end
    end

    assign ld_count  = ld_cnt_q;
    assign st_count  = st_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one DUT with READ_LAT=1 and one with READ_LAT=3,
// each backed by a small data_memory model whose memout is only valid once memget has
// been high for READ_LAT cycles.
module tb_mem_access_ctrl;

    logic        mclk;
    logic        reset_n;

    // READ_LAT = 1 instance
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_rdata, memaddr, memval, memout;
    logic        memget, memset;

    // READ_LAT = 3 instance
    logic        req_valid3, req_ready3, req_we3;
    logic [15:0] req_addr3, req_wdata3;
    logic        rsp_valid3, rsp_ready3, rsp_err3;
    logic [15:0] rsp_rdata3, memaddr3, memval3, memout3;
    logic        memget3, memset3;

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] ld_count, st_count, err_count;
    logic [15:0] ld_count3, st_count3, err_count3;
`endif

    int errors = 0;
    int checks = 0;

    mem_access_ctrl #(.WORD_SIZE(16), .READ_LAT(1), .MEM_DEPTH(256)) u_dut (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .memaddr   (memaddr),
        .memval    (memval),
        .memget    (memget),
        .memset    (memset),
        .memout    (memout)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .ld_count  (ld_count),
        .st_count  (st_count),
        .err_count (err_count)
`endif
    );

    mem_access_ctrl #(.WORD_SIZE(16), .READ_LAT(3), .MEM_DEPTH(256)) u_dut3 (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .req_valid (req_valid3),
        .req_ready (req_ready3),
        .req_we    (req_we3),
        .req_addr  (req_addr3),
        .req_wdata (req_wdata3),
        .rsp_valid (rsp_valid3),
        .rsp_ready (rsp_ready3),
        .rsp_rdata (rsp_rdata3),
        .rsp_err   (rsp_err3),
        .memaddr   (memaddr3),
        .memval    (memval3),
        .memget    (memget3),
        .memset    (memset3),
        .memout    (memout3)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .ld_count  (ld_count3),
        .st_count  (st_count3),
        .err_count (err_count3)
`endif
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    // data_memory models and strobe monitors
    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    int          get_run1 = 0, get_run3 = 0;
    int          set_cnt1 = 0, get_cnt1 = 0;
    int          set_cnt3 = 0, get_cnt3 = 0;
    logic        both_seen = 1'b0;

    always @(posedge mclk) begin
        if (memset)  mem1[memaddr[7:0]]  <= memval;
        if (memset3) mem3[memaddr3[7:0]] <= memval3;
        get_run1 <= memget  ? get_run1 + 1 : 0;
        get_run3 <= memget3 ? get_run3 + 1 : 0;
        if (memset)  set_cnt1 <= set_cnt1 + 1;
        if (memget)  get_cnt1 <= get_cnt1 + 1;
        if (memset3) set_cnt3 <= set_cnt3 + 1;
        if (memget3) get_cnt3 <= get_cnt3 + 1;
        if ((memget && memset) || (memget3 && memset3)) both_seen <= 1'b1;
    end

    assign memout  = (memget && get_run1 >= 0) ? mem1[memaddr[7:0]] : 16'hDEAD;
    assign memout3 = (memget3 && get_run3 >= 2) ? mem3[memaddr3[7:0]] : 16'hDEAD;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset();
        int s0;
        reset_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0005; req_wdata = 16'h0007;
        s0 = set_cnt1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || memset !== 1'b0 ||
                memget !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl cyc%0d: ready=%b valid=%b set=%b get=%b, want all 0",
                         i, req_ready, rsp_valid, memset, memget);
            end
        end
        checks++;
        if (rsp_rdata !== 16'h0 || rsp_err !== 1'b0 || memaddr !== 16'h0 || memval !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h err=%b addr=%h val=%h, want 0",
                     rsp_rdata, rsp_err, memaddr, memval);
        end
        req_valid = 1'b0;
        reset_n = 1'b1;
        step();
        checks++;
        if (set_cnt1 != s0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: memsets=%0d ready=%b, want 0 and 1",
                     set_cnt1 - s0, req_ready);
        end
    endtask

    task automatic test_stores();
        logic [15:0] addrs [3];
        logic [15:0] datas [3];
        int s0;
        addrs = '{16'h1, 16'h2, 16'h3};
        datas = '{16'h1, 16'h4, 16'h9};
        for (int i = 0; i < 3; i++) begin
            s0 = set_cnt1;
            req_valid = 1'b1; req_we = 1'b1; req_addr = addrs[i]; req_wdata = datas[i];
            step();
            req_valid = 1'b0;
            checks++;
            if (memset !== 1'b1 || memget !== 1'b0 || memaddr !== addrs[i] ||
                memval !== datas[i] || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL store_issue %0d: set=%b get=%b addr=%h val=%h valid=%b, want 1 0 %h %h 0",
                         i, memset, memget, memaddr, memval, rsp_valid, addrs[i], datas[i]);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 16'h0 ||
                memset !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL store_resp %0d: valid=%b err=%b rdata=%h set=%b ready=%b, want 1 0 0 0 0",
                         i, rsp_valid, rsp_err, rsp_rdata, memset, req_ready);
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || set_cnt1 - s0 != 1) begin
                errors++;
                $display("FAIL store_done %0d: valid=%b ready=%b memsets=%0d, want 0 1 1",
                         i, rsp_valid, req_ready, set_cnt1 - s0);
            end
        end
    endtask

    task automatic test_loads();
        logic [15:0] addrs [3];
        logic [15:0] exps  [3];
        int g0;
        addrs = '{16'h1, 16'h2, 16'h3};
        exps  = '{16'h1, 16'h4, 16'h9};
        for (int i = 0; i < 3; i++) begin
            g0 = get_cnt1;
            req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[i]; req_wdata = 16'hFFFF;
            step();
            req_valid = 1'b0;
            checks++;
            if (memget !== 1'b1 || memset !== 1'b0 || memaddr !== addrs[i] || memval !== 16'h0) begin
                errors++;
                $display("FAIL load_issue %0d: get=%b set=%b addr=%h val=%h, want 1 0 %h 0",
                         i, memget, memset, memaddr, memval, addrs[i]);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exps[i] || rsp_err !== 1'b0 ||
                memget !== 1'b0 || get_cnt1 - g0 != 1) begin
                errors++;
                $display("FAIL load_resp %0d: valid=%b rdata=%h err=%b get=%b getcycles=%0d, want 1 %h 0 0 1",
                         i, rsp_valid, rsp_rdata, rsp_err, memget, get_cnt1 - g0, exps[i]);
            end
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_idle_rsp_ready();
        rsp_ready = 1'b1;
        step();
        step();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_rsp_ready: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h2;
        step();
        step();
        // A store request held during the busy window must be ignored.
        req_we = 1'b1; req_addr = 16'h7; req_wdata = 16'h5555;
        s0 = set_cnt1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h4 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cyc%0d: valid=%b rdata=%h ready=%b, want 1 0004 0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || set_cnt1 != s0) begin
            errors++;
            $display("FAIL backpressure_done: valid=%b ready=%b memsets=%0d, want 0 1 0",
                     rsp_valid, req_ready, set_cnt1 - s0);
        end
    endtask

    task automatic test_out_of_range();
        int g0;
        int s0;
        g0 = get_cnt1;
        s0 = set_cnt1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0100; req_wdata = 16'h0;
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 16'h0 ||
            memget !== 1'b0 || memaddr !== 16'h2) begin
            errors++;
            $display("FAIL oor_load: valid=%b err=%b rdata=%h get=%b addr=%h, want 1 1 0 0 0002",
                     rsp_valid, rsp_err, rsp_rdata, memget, memaddr);
        end
`ifdef MEM_ACCESS_STATS_EN
        checks++;
        if (err_count !== 16'd1 || st_count !== 16'd3 || ld_count !== 16'd4) begin
            errors++;
            $display("FAIL stats: ld=%0d st=%0d err=%0d, want 4 3 1", ld_count, st_count, err_count);
        end
`endif
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'hFFFF; req_wdata = 16'h1234;
        step();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || memset !== 1'b0) begin
            errors++;
            $display("FAIL oor_store: valid=%b err=%b set=%b, want 1 1 0", rsp_valid, rsp_err, memset);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checks++;
        if (get_cnt1 != g0 || set_cnt1 != s0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL oor_strobes: gets=%0d sets=%0d valid=%b, want 0 0 0",
                     get_cnt1 - g0, set_cnt1 - s0, rsp_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        int seen_valid;
        // Put 9 at address 3 of the READ_LAT=3 memory.
        req_valid3 = 1'b1; req_we3 = 1'b1; req_addr3 = 16'h3; req_wdata3 = 16'h9;
        step();
        req_valid3 = 1'b0;
        step();
        rsp_ready3 = 1'b1;
        step();
        rsp_ready3 = 1'b0;
        // Load, then reset while in WAIT.
        req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 16'h3;
        step();
        req_valid3 = 1'b0;
        step();
        checks++;
        if (memget3 !== 1'b1) begin
            errors++;
            $display("FAIL mid_load_wait: get=%b, want 1", memget3);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (memget3 !== 1'b0 || rsp_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL mid_load_reset: get=%b valid=%b, want 0 0", memget3, rsp_valid3);
        end
        reset_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (rsp_valid3 === 1'b1) seen_valid++;
        end
        checks++;
        if (seen_valid != 0 || req_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL mid_load_no_rsp: valid cycles=%0d ready=%b, want 0 1", seen_valid, req_ready3);
        end
        // Fresh load: memget for 3 cycles, response on the 4th edge after accept.
        req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 16'h3;
        step();
        req_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (memget3 !== 1'b1 || rsp_valid3 !== 1'b0) begin
                errors++;
                $display("FAIL lat3_wait cyc%0d: get=%b valid=%b, want 1 0", i, memget3, rsp_valid3);
            end
            step();
        end
        checks++;
        if (rsp_valid3 !== 1'b1 || rsp_rdata3 !== 16'h9 || rsp_err3 !== 1'b0 || memget3 !== 1'b0) begin
            errors++;
            $display("FAIL lat3_resp: valid=%b rdata=%h err=%b get=%b, want 1 0009 0 0",
                     rsp_valid3, rsp_rdata3, rsp_err3, memget3);
        end
        rsp_ready3 = 1'b1;
        step();
        rsp_ready3 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b0;
        test_reset();
        test_stores();
        test_loads();
        test_idle_rsp_ready();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_load();
        checks++;
        if (both_seen !== 1'b0) begin
            errors++;
            $display("FAIL get_set_exclusive: overlap=%b, want 0", both_seen);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
